// File: rtl/anillo_pkg.sv
// anillo_pkg: shared definitions for the systolic-ring sequencer.
//   W_DEF / N_DEF : default data width and ring length
//   state_t       : sequencer FSM states
//   coef_col      : column of A fed to PE i at RUN step k, i.e. (i-k) mod n
package anillo_pkg;

   localparam int W_DEF = 16;
   localparam int N_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_WAIT,
      S_CAPT,
      S_OUT
   } state_t;

   // SV '%' keeps the sign of the dividend, so fold negatives back into 0..n-1.
   function automatic int coef_col(input int i, input int k, input int n = N_DEF);
      int r;
      r = (i - k) % n;
      if (r < 0) r = r + n;
      return r;
   endfunction

endpackage

// File: rtl/anillo_res_buf.sv
// anillo_res_buf: DEPTH x W capture buffer between the ring output and the
// host result stream.
//   clk, reset        : clock, synchronous active-high reset (clears pointers)
//   wr_en, wr_data    : capture port, one entry per asserted cycle
//   rd_en             : read side enabled (sequencer is presenting results)
//   rd_ready          : consumer accepts current word
//   rd_valid, rd_data : current word (rd_data is 0 whenever rd_valid is low)
//   rd_last           : current word is entry DEPTH-1
//   rd_done           : final word handshaken this cycle
module anillo_res_buf #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   input  logic         rd_ready,
   output logic         rd_valid,
   output logic [W-1:0] rd_data,
   output logic         rd_last,
   output logic         rd_done
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic                    fire;

   assign rd_valid = rd_en;
   assign fire     = rd_en & rd_ready;
   assign rd_last  = rd_en && (int'(rd_ptr) == DEPTH - 1);
   assign rd_done  = fire & rd_last;
   // Gated so the stream reads as zero outside a result burst.
   assign rd_data  = rd_en ? mem[rd_ptr] : '0;

   // Storage is not reset; only the pointers define what is meaningful.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + PW'(1);
         if (fire)
            rd_ptr <= rd_last ? '0 : rd_ptr + PW'(1);
      end
   end

endmodule

// File: rtl/anillo_secuenciador.sv
// anillo_secuenciador: host-side driver/collector for an N-PE systolic ring
// computing y = A*x.
//   clk, reset             : clock, synchronous active-high reset
//   mat_we/addr/wdata      : host write of A[row][col] at row*N+col (IDLE only)
//   vec_we/addr/wdata      : host write of x[i] (IDLE only)
//   start                  : run request, honoured in IDLE only
//   busy                   : high in every state except IDLE
//   ring_reset             : one-cycle load pulse to the PEs
//   ring_x                 : x vector, PE i at [i*W +: W]
//   ring_a                 : coefficient per PE during RUN, else 0
//   ring_y                 : ring output sample (last PE)
//   res_valid/ready/data/last : result stream, CAP_COUNT words per run
//   perf_runs              : completed-run counter
// Build option: define ANILLO_SECUENCIADOR_PERF_EN to enable perf_runs;
// otherwise it is tied to zero.
module anillo_secuenciador
   import anillo_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int N         = N_DEF,
   parameter int CAP_DELAY = 1,
   parameter int CAP_COUNT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mat_we,
   input  logic [$clog2(N*N)-1:0] mat_addr,
   input  logic [W-1:0]           mat_wdata,
   input  logic                   vec_we,
   input  logic [$clog2(N)-1:0]   vec_addr,
   input  logic [W-1:0]           vec_wdata,
   input  logic                   start,
   output logic                   busy,
   output logic                   ring_reset,
   output logic [N*W-1:0]         ring_x,
   output logic [N*W-1:0]         ring_a,
   input  logic [W-1:0]           ring_y,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [W-1:0]           res_data,
   output logic                   res_last,
   output logic [15:0]            perf_runs
);

   localparam int MA   = $clog2(N*N);
   localparam int MAXC = (N > CAP_DELAY) ? ((N > CAP_COUNT) ? N : CAP_COUNT)
                                         : ((CAP_DELAY > CAP_COUNT) ? CAP_DELAY : CAP_COUNT);
   localparam int CW   = $clog2(MAXC + 1);

   state_t                  state, state_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic [N*N-1:0][W-1:0]   mat_q;
   logic [N-1:0][W-1:0]     vec_q;
   logic [N-1:0][W-1:0]     a_lane;
   logic                    cap_we;
   logic                    out_en;
   logic                    out_done;

   // Host storage: writes land only while idle, so a run always sees a
   // frozen A and x. A write coinciding with start is still idle and counts.
   always_ff @(posedge clk) begin
      if (state == S_IDLE) begin
         if (mat_we) mat_q[mat_addr] <= mat_wdata;
         if (vec_we) vec_q[vec_addr] <= vec_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // cnt is the step index inside RUN, WAIT and CAPT; it restarts at each entry.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      ring_reset = 1'b0;
      cap_we     = 1'b0;
      out_en     = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (start) state_n = S_LOAD;
         end
         S_LOAD: begin
            ring_reset = 1'b1;
            cnt_n      = '0;
            state_n    = S_RUN;
         end
         S_RUN: begin
            if (int'(cnt) == N - 1) begin
               cnt_n   = '0;
               state_n = (CAP_DELAY == 0) ? S_CAPT : S_WAIT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_WAIT: begin
            if (int'(cnt) == CAP_DELAY - 1) begin
               cnt_n   = '0;
               state_n = S_CAPT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_CAPT: begin
            cap_we = 1'b1;
            if (int'(cnt) == CAP_COUNT - 1) begin
               cnt_n   = '0;
               state_n = S_OUT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_OUT: begin
            out_en = 1'b1;
            if (out_done) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // Rotated coefficient feed: at step k PE i takes A[i][(i-k) mod N], so each
   // x element meets its matching coefficient as it travels round the ring.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign a_lane[gi] = (state == S_RUN)
                        ? mat_q[MA'(gi * N + coef_col(gi, int'(cnt), N))]
                        : '0;
   end

   assign ring_a = a_lane;
   assign ring_x = vec_q;

   anillo_res_buf #(
      .W     (W),
      .DEPTH (CAP_COUNT)
   ) u_res_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (cap_we),
      .wr_data  (ring_y),
      .rd_en    (out_en),
      .rd_ready (res_ready),
      .rd_valid (res_valid),
      .rd_data  (res_data),
      .rd_last  (res_last),
      .rd_done  (out_done)
   );

`ifdef ANILLO_SECUENCIADOR_PERF_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk) begin
      if (reset)         perf_q <= '0;
      else if (out_done) perf_q <= perf_q + 16'd1;
   end

   assign perf_runs = perf_q;
`else
   assign perf_runs = '0;
`endif

endmodule

// File: tb/tb_anillo_secuenciador.sv
module tb_anillo_secuenciador;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int CD = 1;
   localparam int CC = 4;
   // Offsets (in cycles) from the LOAD cycle.
   localparam int CAPT_OFF = 1 + N + CD;
   localparam int OUT_OFF  = CAPT_OFF + CC;

   logic           clk = 1'b0;
   logic           reset;
   logic           mat_we;
   logic [3:0]     mat_addr;
   logic [W-1:0]   mat_wdata;
   logic           vec_we;
   logic [1:0]     vec_addr;
   logic [W-1:0]   vec_wdata;
   logic           start;
   logic           busy;
   logic           ring_reset;
   logic [N*W-1:0] ring_x;
   logic [N*W-1:0] ring_a;
   logic [W-1:0]   ring_y;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_data;
   logic           res_last;
   logic [15:0]    perf_runs;

   anillo_secuenciador #(.W(W), .N(N), .CAP_DELAY(CD), .CAP_COUNT(CC)) dut (
      .clk        (clk),
      .reset      (reset),
      .mat_we     (mat_we),
      .mat_addr   (mat_addr),
      .mat_wdata  (mat_wdata),
      .vec_we     (vec_we),
      .vec_addr   (vec_addr),
      .vec_wdata  (vec_wdata),
      .start      (start),
      .busy       (busy),
      .ring_reset (ring_reset),
      .ring_x     (ring_x),
      .ring_a     (ring_a),
      .ring_y     (ring_y),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_last   (res_last),
      .perf_runs  (perf_runs)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      bit           last;
   } exp_t;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           run_s = -1;   // cycle index of the LOAD cycle of the current run
   int           run_e = -1;   // last busy cycle of the run, < run_s while open
   int           runs_done = 0;
   bit           chk_en = 1'b0;
   bit           seen_valid = 1'b0;
   bit           ry_seq = 1'b0;
   int           rdy_mode = 0;
   logic [W-1:0] amod [N*N];
   logic [W-1:0] vmod [N];
   exp_t         exp_q [$];
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic         prev_last;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit active(input int c);
      return (run_s >= 0) && (c >= run_s) && ((run_e < run_s) || (c <= run_e));
   endfunction

   // PE i at step k multiplies by A[i][(i-k) mod N].
   function automatic logic [N*W-1:0] exp_ring_a(input int k);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++)
         v[i*W +: W] = amod[i*N + (((i - k) % N) + N) % N];
      return v;
   endfunction

   function automatic logic [N*W-1:0] exp_ring_x();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = vmod[i];
      return v;
   endfunction

   // Ring output and consumer readiness, changed just after each edge.
   always @(posedge clk) begin
      #1;
      if (ry_seq && run_s >= 0) ring_y = W'(100 + (cyc - run_s - CAPT_OFF));
      else                      ring_y = W'($urandom);
      case (rdy_mode)
         0:       res_ready = 1'b1;
         1:       res_ready = ~res_ready;
         default: res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Phase checker: control outputs per cycle of the run; records the ring
   // samples of the capture window as expected result words.
   always @(negedge clk) begin : chk_p
      int   c;
      int   d;
      exp_t e;
      if (chk_en) begin
         c = cyc;
         chk("ring_x", ring_x, exp_ring_x());
         if (active(c)) begin
            d = c - run_s;
            chk("busy", busy, 1'b1);
            chk("ring_reset", ring_reset, d == 0);
            chk("ring_a", ring_a, (d >= 1 && d <= N) ? exp_ring_a(d - 1) : '0);
            chk("res_valid", res_valid, d >= OUT_OFF);
            if (res_valid && !seen_valid) begin
               seen_valid = 1'b1;
               // edges from the cycle start was driven to the first valid cycle
               chk("latency", c - (run_s - 1), 1 + 1 + N + CD + CC);
            end
            if (d >= CAPT_OFF && d < OUT_OFF) begin
               e.data = ring_y;
               e.last = (d == OUT_OFF - 1);
               exp_q.push_back(e);
            end
         end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_ring_reset", ring_reset, 1'b0);
            chk("idle_ring_a", ring_a, '0);
            chk("idle_res_valid", res_valid, 1'b0);
         end
      end
   end

   // Result monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin : mon_p
      exp_t e;
      if (chk_en) begin
         if (res_valid && prev_stall) begin
            chk("hold_data", res_data, prev_data);
            chk("hold_last", res_last, prev_last);
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("res_extra", res_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_last", res_last, e.last);
               if (e.last) begin
                  run_e = cyc;
                  runs_done++;
               end
            end
         end
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         prev_last  = res_last;
      end
   end

   task automatic wr_mat(input int a, input logic [W-1:0] v, input bit acc);
      mat_we = 1'b1; mat_addr = 4'(a); mat_wdata = v;
      tick();
      mat_we = 1'b0;
      if (acc) amod[a] = v;
   endtask

   task automatic wr_vec(input int a, input logic [W-1:0] v);
      vec_we = 1'b1; vec_addr = 2'(a); vec_wdata = v;
      tick();
      vec_we = 1'b0;
      vmod[a] = v;
   endtask

   // Start a run; optionally write x in the same cycle (the run must use it).
   task automatic do_start(input bit wv);
      int           a;
      logic [W-1:0] v;
      a = $urandom_range(0, N - 1);
      v = W'($urandom);
      start = 1'b1; vec_we = wv; vec_addr = 2'(a); vec_wdata = v;
      tick();
      run_s = cyc; run_e = -1; seen_valid = 1'b0;
      if (wv) vmod[a] = v;
      start = 1'b0; vec_we = 1'b0;
   endtask

   task automatic wait_d(input int x);
      int b = 0;
      while ((cyc - run_s < x) && b < 100) begin tick(); b++; end
   endtask

   task automatic wait_run_done();
      int b = 0;
      while (active(cyc) && b < 300) begin tick(); b++; end
      if (active(cyc)) begin
         chk("run_timeout", busy, 1'b0);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         run_e = cyc - 1;
         exp_q.delete();
      end
   endtask

   task automatic chk_perf();
`ifdef ANILLO_SECUENCIADOR_PERF_EN
      chk("perf_runs", perf_runs, 16'(runs_done));
`else
      chk("perf_runs", perf_runs, 16'd0);
`endif
   endtask

   initial begin
      reset = 1'b1; mat_we = 1'b0; mat_addr = '0; mat_wdata = '0;
      vec_we = 1'b0; vec_addr = '0; vec_wdata = '0; start = 1'b0;
      ring_y = '0; res_ready = 1'b0;

      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ring_reset", ring_reset, 1'b0);
      chk("rst_ring_a", ring_a, '0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_last", res_last, 1'b0);
      chk("rst_res_data", res_data, '0);
      chk("rst_perf_runs", perf_runs, 16'd0);
      tick();
      reset = 1'b0;

      // Identity A, x = {1,2,3,4}; ring_y counts 100.. over the capture window.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) wr_mat(i*N + j, W'(i == j), 1'b1);
      for (int i = 0; i < N; i++) wr_vec(i, W'(i + 1));
      chk_en = 1'b1;
      ry_seq = 1'b1; rdy_mode = 0;
      do_start(1'b0);
      wait_run_done();
      chk_perf();

      // A[i][j] = 10*i+j, toggling ready; dropped writes and ignored starts.
      ry_seq = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) wr_mat(i*N + j, W'(10*i + j), 1'b1);
      rdy_mode = 1;
      do_start(1'b1);
      wait_d(2);
      vec_we = 1'b1; vec_addr = 2'd1; vec_wdata = 16'h1234;
      wr_mat(5, 16'hBEEF, 1'b0);
      vec_we = 1'b0;
      wait_d(4);
      start = 1'b1; tick(); start = 1'b0;
      wait_d(OUT_OFF);
      start = 1'b1; tick(); start = 1'b0;
      wait_run_done();
      chk_perf();

      // Same matrix again: A[1][1] must still be 11.
      rdy_mode = 2;
      do_start(1'b0);
      wait_run_done();
      chk_perf();

      // Abort at RUN step 2, then a full run.
      do_start(1'b0);
      wait_d(3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run_e = run_s + 3;
      exp_q.delete();
      tick();
      tick();
      chk_perf();
      do_start(1'b1);
      wait_run_done();
      chk_perf();

      // Random matrices, vectors and consumer behaviour.
      for (int r = 0; r < 6; r++) begin
         int nw;
         nw = $urandom_range(0, 5);
         for (int w = 0; w < nw; w++) wr_mat($urandom_range(0, N*N - 1), W'($urandom), 1'b1);
         if ($urandom_range(0, 1) == 1) wr_vec($urandom_range(0, N - 1), W'($urandom));
         rdy_mode = $urandom_range(0, 2);
         do_start(1'($urandom_range(0, 1)));
         wait_run_done();
         chk_perf();
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
